// File: rtl/gb_pkg.sv
// Shared Game Boy interrupt definitions: register addresses, source bit indices
// and the acknowledge handshake states.
package gb_pkg;

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    localparam int unsigned IRQ_VBLANK = 0;
    localparam int unsigned IRQ_LCD    = 1;
    localparam int unsigned IRQ_TIMER  = 2;
    localparam int unsigned IRQ_SERIAL = 3;
    localparam int unsigned IRQ_JOYPAD = 4;
    localparam int unsigned NUM_IRQ    = IRQ_JOYPAD + 1;

    localparam logic [7:0] VECTOR_BASE = 8'h40;

    typedef enum logic {IDLE, SERVICE} state_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side bus and interrupt handshake between the core and the interrupt controller.
interface interrupt_controller_if;

    logic [15:0] A_cpu;
    logic [7:0]  Di_cpu;
    logic        wr_cpu;
    logic        int_ack;
    logic [7:0]  IF;
    logic [7:0]  IE;
    logic        int_req;
    logic        int_pending;
    logic [7:0]  int_vector;

    modport master (
        output A_cpu, Di_cpu, wr_cpu, int_ack,
        input  IF, IE, int_req, int_pending, int_vector
    );

    modport slave (
        input  A_cpu, Di_cpu, wr_cpu, int_ack,
        output IF, IE, int_req, int_pending, int_vector
    );

endinterface

// File: rtl/irq_priority_enc.sv
// Combinational lowest-bit-wins priority encoder for the pending interrupt mask.
module irq_priority_enc
    import gb_pkg::*;
(
    input  logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] onehot,
    output logic [2:0]         index,
    output logic               valid
);

    always_comb begin
        // Two's-complement trick isolates the lowest set bit.
        onehot = mask & (~mask + 5'd1);
        valid  = |mask;
        index  = '0;
        for (int i = NUM_IRQ - 1; i >= int'(IRQ_VBLANK); i--) begin
            if (mask[i]) index = 3'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Owns IF/IE, latches peripheral request edges and runs the request/ack handshake.
module interrupt_controller
    import gb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_IRQ-1:0]   irq_src,
    interrupt_controller_if.slave bus
);

    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [7:0]         ie_q;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [7:0]         vec_q;
    state_t             state_q;

    logic [NUM_IRQ-1:0] pend_mask, win_onehot, ack_clear, rise, if_wr_val;
    logic [2:0]         win_index;
    logic               win_valid;
    logic [7:0]         comb_vec;
    logic               wr_if, wr_ie, take;

    assign pend_mask = if_q & ie_q[NUM_IRQ-1:0];

    irq_priority_enc u_enc (
        .mask   (pend_mask),
        .onehot (win_onehot),
        .index  (win_index),
        .valid  (win_valid)
    );

    always_comb begin
        wr_if     = bus.wr_cpu && (bus.A_cpu == ADDR_IF);
        wr_ie     = bus.wr_cpu && (bus.A_cpu == ADDR_IE);
        rise      = irq_src & ~irq_prev_q;
        comb_vec  = win_valid ? (VECTOR_BASE + {2'b00, win_index, 3'b000}) : 8'h00;
        take      = (state_q == IDLE) && bus.int_ack && win_valid;
        ack_clear = take ? win_onehot : '0;
        if_wr_val = wr_if ? bus.Di_cpu[NUM_IRQ-1:0] : if_q;
        // A new edge beats both a CPU write and an acknowledge clear.
        if_d      = (if_wr_val & ~ack_clear) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q       <= '0;
            ie_q       <= 8'h00;
            irq_prev_q <= '0;
            vec_q      <= 8'h00;
            state_q    <= IDLE;
        end else begin
            if_q       <= if_d;
            irq_prev_q <= irq_src;
            if (wr_ie) ie_q <= bus.Di_cpu;
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        vec_q   <= comb_vec;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (!bus.int_ack) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.IF          = {3'b111, if_q};
    assign bus.IE          = ie_q;
    assign bus.int_pending = win_valid;
    assign bus.int_req     = (state_q == IDLE) && win_valid;
    assign bus.int_vector  = (state_q == SERVICE) ? vec_q : comb_vec;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: directed plan plus random traffic against a behavioural model.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] irq_src;

    interrupt_controller_if bus ();

    interrupt_controller dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] if_r;
        logic [7:0] ie_r;
        logic       req;
        logic       pend;
        logic [7:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model state
    bit [4:0] m_if;
    bit [7:0] m_ie;
    bit [4:0] m_prev;
    bit       m_srv;
    bit [7:0] m_vec;

    function automatic int winner(input bit [4:0] f, input bit [7:0] e);
        for (int i = 0; i < 5; i++) if (f[i] && e[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit [15:0] a, input bit [7:0] d, input bit wr,
                        input bit [4:0] src, input bit ack);
        int   w;
        bit [4:0] nf;
        exp_t e;
        reset       = rst;
        bus.A_cpu   = a;
        bus.Di_cpu  = d;
        bus.wr_cpu  = wr;
        bus.int_ack = ack;
        irq_src     = src;
        if (rst) begin
            m_if = 0; m_ie = 0; m_prev = 0; m_srv = 0; m_vec = 0;
        end else begin
            w  = winner(m_if, m_ie);
            nf = (wr && a == 16'hFF0F) ? d[4:0] : m_if;
            if (!m_srv && ack && w >= 0) begin
                nf[w] = 1'b0;
                m_vec = 8'h40 + 8'(8 * w);
                m_srv = 1;
            end else if (m_srv && !ack) begin
                m_srv = 0;
            end
            for (int i = 0; i < 5; i++) if (src[i] && !m_prev[i]) nf[i] = 1'b1;
            if (wr && a == 16'hFFFF) m_ie = d;
            m_prev = src;
            m_if   = nf;
        end
        w      = winner(m_if, m_ie);
        e.if_r = {3'b111, m_if};
        e.ie_r = m_ie;
        e.pend = (w >= 0);
        e.req  = !m_srv && (w >= 0);
        e.vec  = m_srv ? m_vec : ((w >= 0) ? 8'h40 + 8'(8 * w) : 8'h00);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit [4:0] src, input bit ack);
        step(0, 16'h0000, 8'h00, 0, src, ack);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set, compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("IF", bus.IF, e.if_r);
                check("IE", bus.IE, e.ie_r);
                check("int_req", 8'(bus.int_req), 8'(e.req));
                check("int_pending", 8'(bus.int_pending), 8'(e.pend));
                check("int_vector", bus.int_vector, e.vec);
            end
        end
    end

    initial begin
        bit [4:0] src;
        bit       ack;
        reset = 1; bus.A_cpu = 0; bus.Di_cpu = 0; bus.wr_cpu = 0; bus.int_ack = 0; irq_src = 0;
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_IF", bus.IF, 8'hE0);
        check("rst_IE", bus.IE, 8'h00);
        check("rst_req", 8'(bus.int_req), 8'h00);
        check("rst_vec", bus.int_vector, 8'h00);

        step(0, 16'hFFFF, 8'h04, 1, 0, 0);
        idle(5'b00100, 0);
        check("timer_IF", bus.IF, 8'hE4);
        check("timer_req", 8'(bus.int_req), 8'h01);
        check("timer_vec", bus.int_vector, 8'h50);
        idle(0, 1);
        check("ack_IF", bus.IF, 8'hE0);
        check("ack_req", 8'(bus.int_req), 8'h00);
        idle(0, 1);
        idle(0, 0);

        step(0, 16'hFFFF, 8'h1F, 1, 0, 0);
        idle(5'b10010, 0);
        check("prio_vec", bus.int_vector, 8'h48);
        idle(5'b10010, 1);
        idle(5'b10010, 0);
        check("next_vec", bus.int_vector, 8'h60);
        check("next_IF", bus.IF, 8'hF0);

        idle(0, 0);
        step(0, 16'hFF0F, 8'h00, 1, 5'b00001, 0);
        check("wr_vs_rise_IF", bus.IF, 8'hE1);
        idle(5'b00001, 1);
        idle(5'b00000, 1);
        idle(5'b00001, 1);
        check("resvc_IF", bus.IF, 8'hE1);
        check("resvc_vec", bus.int_vector, 8'h40);
        idle(0, 0);

        step(0, 16'hFF0F, 8'h00, 1, 0, 0);
        step(0, 16'hFFFF, 8'h08, 1, 0, 0);
        for (int i = 0; i < 10; i++) idle(5'b01000, (i == 4) || (i == 5));
        check("hold_IF", bus.IF, 8'hE0);

        idle(5'b01000, 0);
        idle(0, 0);
        idle(5'b01000, 0);
        idle(5'b01000, 1);
        step(1, 0, 0, 0, 5'b01000, 1);
        check("svc_rst_IF", bus.IF, 8'hE0);
        check("svc_rst_req", 8'(bus.int_req), 8'h00);
        check("svc_rst_vec", bus.int_vector, 8'h00);

        src = 0; ack = 0;
        for (int i = 0; i < 400; i++) begin
            bit [15:0] a;
            case ($urandom_range(3))
                0: a = 16'hFF0F;
                1: a = 16'hFFFF;
                2: a = 16'hFF00 | 16'($urandom_range(255));
                default: a = 16'($urandom);
            endcase
            if ($urandom_range(3) == 0) src = 5'($urandom);
            if ($urandom_range(2) == 0) ack = ~ack;
            step($urandom_range(63) == 0, a, 8'($urandom), $urandom_range(4) == 0, src, ack);
        end
        idle(0, 0);
        @(posedge clk);
        #3;
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
